// File: rtl/apb_regbank_slave_if.sv
// APB completer bus bundle for the register bank.
// The requester drives the master view; the bank uses the slave view.
interface apb_regbank_slave_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
);
    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [DATAWIDTH-1:0] PWDATA;
    logic [3:0]           PSTRB;
    logic [DATAWIDTH-1:0] PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regbank_slave.sv
// APB register bank completer with programmable wait states.
// Exposes register contents and per-register write pulses locally.
module apb_regbank_slave #(
    parameter int                  ADDRWIDTH   = 16,
    parameter int                  DATAWIDTH   = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_CYCLES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = 8'h80
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          PCLKEN,
    apb_regbank_slave_if.slave            apb,
    input  logic [NUM_REGS*DATAWIDTH-1:0] STATUS_IN,
    output logic [NUM_REGS*DATAWIDTH-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]           WR_PULSE
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int                   IDXW     = $clog2(NUM_REGS);
    localparam logic [ADDRWIDTH-3:0] NREGS_A  = (ADDRWIDTH-2)'(NUM_REGS);
    localparam logic [3:0]           CNT_INIT = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  write_q, write_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATAWIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATAWIDTH-1:0]  regs_d [NUM_REGS];

    logic [ADDRWIDTH-3:0]  addr_idx;
    logic                  setup_err;
    logic                  ready;
    logic                  commit;

    // Decode target slot and error status from the SETUP-phase address
    always_comb begin
        addr_idx  = apb.PADDR[ADDRWIDTH-1:2];
        setup_err = (apb.PADDR[1:0] != 2'b00);
        if (addr_idx >= NREGS_A)
            setup_err = 1'b1;
        else if (apb.PWRITE && RO_MASK[addr_idx[IDXW-1:0]])
            setup_err = 1'b1;
    end

    // Transfer FSM: SETUP latches the access, ACCESS counts waits then commits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        write_d = write_q;
        commit  = 1'b0;
        if (PCLKEN) begin
            if (apb.PSEL && !apb.PENABLE) begin
                // A SETUP seen in ACCESS restarts the transfer
                state_d = ACCESS;
                cnt_d   = CNT_INIT;
                idx_d   = addr_idx[IDXW-1:0];
                err_d   = setup_err;
                write_d = apb.PWRITE;
            end else if (state_q == ACCESS) begin
                if (apb.PSEL && apb.PENABLE) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // Completion outputs; read data only while the completing beat is shown
    always_comb begin
        ready       = (state_q == ACCESS) && (cnt_q == 4'd0);
        apb.PREADY  = ready;
        apb.PSLVERR = ready && err_q;
        apb.PRDATA  = '0;
        if (ready && !write_q && !err_q) begin
            if (RO_MASK[idx_q])
                apb.PRDATA = STATUS_IN[idx_q*DATAWIDTH +: DATAWIDTH];
            else
                apb.PRDATA = regs_q[idx_q];
        end
    end

    // Byte-lane register update and write pulse on a good write commit
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (commit && write_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (apb.PSTRB[b])
                    regs_d[idx_q][8*b +: 8] = apb.PWDATA[8*b +: 8];
            end
            wr_pulse_d[idx_q] = 1'b1;
        end
    end

    // State, counter, latched decode, registers and pulse flops
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            write_q    <= write_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    // Flatten RW registers for local hardware; read-only slots show 0
    always_comb begin
        REG_OUT = '0;
        for (int i = 0; i < NUM_REGS; i++)
            REG_OUT[i*DATAWIDTH +: DATAWIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end

    assign WR_PULSE = wr_pulse_q;
endmodule

// File: tb/tb_apb_regbank_slave.sv
// Bench for apb_regbank_slave: two instances (1 and 2 wait states)
// checked every cycle against a transaction-level register model.
module tb_apb_regbank_slave;
    localparam int         AW = 16;
    localparam int         DW = 32;
    localparam int         NR = 8;
    localparam logic [7:0] RO = 8'h80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pclken = 1'b1;
    always #5 clk = ~clk;

    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    int            tgt = 0;
    int            div = 1;
    int            cyc = 0;
    logic [NR*DW-1:0] status = '0;

    logic [NR*DW-1:0] reg_out0, reg_out1;
    logic [NR-1:0]    wr_pulse0, wr_pulse1;

    int checks = 0;
    int failures = 0;

    apb_regbank_slave_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus0 ();
    apb_regbank_slave_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus1 ();

    assign bus0.PSEL    = psel && (tgt == 0);
    assign bus0.PENABLE = penable;
    assign bus0.PADDR   = paddr;
    assign bus0.PWRITE  = pwrite;
    assign bus0.PWDATA  = pwdata;
    assign bus0.PSTRB   = pstrb;
    assign bus1.PSEL    = psel && (tgt == 1);
    assign bus1.PENABLE = penable;
    assign bus1.PADDR   = paddr;
    assign bus1.PWRITE  = pwrite;
    assign bus1.PWDATA  = pwdata;
    assign bus1.PSTRB   = pstrb;

    apb_regbank_slave #(
        .ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_REGS(NR),
        .WAIT_CYCLES(1), .RO_MASK(RO)
    ) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .PCLKEN(pclken), .apb(bus0.slave),
        .STATUS_IN(status), .REG_OUT(reg_out0), .WR_PULSE(wr_pulse0)
    );

    apb_regbank_slave #(
        .ADDRWIDTH(AW), .DATAWIDTH(DW), .NUM_REGS(NR),
        .WAIT_CYCLES(2), .RO_MASK(RO)
    ) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .PCLKEN(pclken), .apb(bus1.slave),
        .STATUS_IN(status), .REG_OUT(reg_out1), .WR_PULSE(wr_pulse1)
    );

    // PCLKEN: high one cycle in div
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        pclken = ((cyc % div) == 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] slot(input logic [NR*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_reg [2][NR];
    bit            m_busy [2];
    int            m_en [2];
    int            m_start [2];
    logic [AW-1:0] m_addr [2];
    bit            m_wr [2];
    logic [NR-1:0] m_pulse [2];

    function automatic int wt(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit bad(input logic [AW-1:0] a, input bit w);
        int i;
        i = int'(a >> 2);
        if (a[1:0] != 2'b00) return 1'b1;
        if (i >= NR) return 1'b1;
        return w && (((RO >> i) & 8'h01) != 8'h00);
    endfunction

    // Ready once WAIT enabled access cycles have elapsed after SETUP
    function automatic bit m_ready(input int d);
        return m_busy[d] && ((m_en[d] - m_start[d]) >= wt(d));
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NR; i++) m_reg[d][i] = '0;
                m_busy[d] = 1'b0;
                m_en[d] = 0;
                m_start[d] = 0;
                m_addr[d] = '0;
                m_wr[d] = 1'b0;
                m_pulse[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit sel;
                bit rdy;
                logic [NR-1:0] p;
                int idx;
                sel = psel && (tgt == d);
                p = '0;
                if (pclken) begin
                    rdy = m_ready(d);
                    m_en[d]++;
                    if (sel && !penable) begin
                        m_busy[d] = 1'b1;
                        m_start[d] = m_en[d];
                        m_addr[d] = paddr;
                        m_wr[d] = pwrite;
                    end else if (m_busy[d]) begin
                        if (sel && penable) begin
                            if (rdy) begin
                                m_busy[d] = 1'b0;
                                if (m_wr[d] && !bad(m_addr[d], 1'b1)) begin
                                    idx = int'(m_addr[d] >> 2);
                                    for (int b = 0; b < 4; b++)
                                        if (pstrb[b]) m_reg[d][idx][8*b +: 8] = pwdata[8*b +: 8];
                                    p[idx] = 1'b1;
                                end
                            end
                        end else begin
                            m_busy[d] = 1'b0;
                        end
                    end
                end
                m_pulse[d] = p;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    task automatic compare(input int d);
        logic          rdy, er;
        logic [DW-1:0] rd;
        logic [NR*DW-1:0] ro;
        logic [NR-1:0] wp;
        bit            e_rdy, e_err;
        logic [DW-1:0] e_rd;
        int            idx;
        rdy = (d == 0) ? bus0.PREADY : bus1.PREADY;
        er  = (d == 0) ? bus0.PSLVERR : bus1.PSLVERR;
        rd  = (d == 0) ? bus0.PRDATA : bus1.PRDATA;
        ro  = (d == 0) ? reg_out0 : reg_out1;
        wp  = (d == 0) ? wr_pulse0 : wr_pulse1;
        e_rdy = m_ready(d);
        e_err = e_rdy && bad(m_addr[d], m_wr[d]);
        e_rd  = '0;
        if (e_rdy && !m_wr[d] && !e_err) begin
            idx = int'(m_addr[d] >> 2);
            e_rd = (((RO >> idx) & 8'h01) != 8'h00) ? slot(status, idx) : m_reg[d][idx];
        end
        chk($sformatf("d%0d PREADY", d), 64'(rdy), 64'(e_rdy));
        chk($sformatf("d%0d PSLVERR", d), 64'(er), 64'(e_err));
        chk($sformatf("d%0d PRDATA", d), 64'(rd), 64'(e_rd));
        chk($sformatf("d%0d WR_PULSE", d), 64'(wp), 64'(m_pulse[d]));
        for (int i = 0; i < NR; i++)
            chk($sformatf("d%0d REG_OUT[%0d]", d, i), 64'(slot(ro, i)),
                64'((((RO >> i) & 8'h01) != 8'h00) ? '0 : m_reg[d][i]));
    endtask

    initial forever begin
        @(negedge clk);
        compare(0);
        compare(1);
    end

    // ---------------- driver ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic en_edge(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk);
            if (pclken) ok = 1'b1;
        end
    endtask

    task automatic xfer(input int d, input logic [AW-1:0] a, input bit w,
                        input logic [DW-1:0] wd, input logic [3:0] st,
                        output logic [DW-1:0] rd, output bit er, output int waits);
        bit ok, r, done;
        tgt = d; paddr = a; pwrite = w; pwdata = wd; pstrb = st;
        psel = 1'b1; penable = 1'b0;
        rd = '0; er = 1'b0; waits = 0; done = 1'b0;
        en_edge(ok);
        if (!ok) chk("setup timeout", 64'd0, 64'd1);
        #1 penable = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            r  = (d == 0) ? bus0.PREADY : bus1.PREADY;
            er = (d == 0) ? bus0.PSLVERR : bus1.PSLVERR;
            rd = (d == 0) ? bus0.PRDATA : bus1.PRDATA;
            @(posedge clk);
            if (pclken) begin
                if (r) done = 1'b1;
                else waits++;
            end
        end
        if (!done) chk("access timeout", 64'd0, 64'd1);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    logic [DW-1:0] rd;
    bit            er;
    int            waits;

    initial begin
        status[7*DW +: DW] = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset PREADY", 64'(bus0.PREADY), 64'd0);
        chk("reset REG_OUT", 64'(reg_out0[63:0]), 64'd0);
        rst_n = 1'b1;
        sync();

        // 1: full write to reg 1, one wait state
        xfer(0, 16'h0004, 1'b1, 32'hDEADBEEF, 4'b1111, rd, er, waits);
        chk("t1 waits", 64'(waits), 64'd1);
        chk("t1 PSLVERR", 64'(er), 64'd0);
        @(negedge clk);
        chk("t1 REG_OUT[1]", 64'(slot(reg_out0, 1)), 64'hDEADBEEF);
        chk("t1 WR_PULSE", 64'(wr_pulse0), 64'h02);
        @(negedge clk);
        chk("t1 WR_PULSE off", 64'(wr_pulse0), 64'h00);
        sync();

        // 2: byte-lane write then readback
        xfer(0, 16'h0004, 1'b1, 32'h0000AB00, 4'b0010, rd, er, waits);
        xfer(0, 16'h0004, 1'b0, 32'h0, 4'b0000, rd, er, waits);
        chk("t2 PRDATA", 64'(rd), 64'hDEADABEF);
        chk("t2 PSLVERR", 64'(er), 64'd0);
        chk("t2 REG_OUT[1]", 64'(slot(reg_out0, 1)), 64'hDEADABEF);

        // 3: read-only slot
        xfer(0, 16'h001C, 1'b0, 32'h0, 4'b0000, rd, er, waits);
        chk("t3 RO read", 64'(rd), 64'h12345678);
        chk("t3 RO read err", 64'(er), 64'd0);
        xfer(0, 16'h001C, 1'b1, 32'hFFFFFFFF, 4'b1111, rd, er, waits);
        chk("t3 RO write err", 64'(er), 64'd1);
        @(negedge clk);
        chk("t3 WR_PULSE", 64'(wr_pulse0), 64'h00);
        chk("t3 REG_OUT[7]", 64'(slot(reg_out0, 7)), 64'h0);
        sync();

        // 4: out of range and misaligned
        xfer(0, 16'h0020, 1'b0, 32'h0, 4'b0000, rd, er, waits);
        chk("t4 range err", 64'(er), 64'd1);
        chk("t4 range data", 64'(rd), 64'h0);
        xfer(0, 16'h0005, 1'b0, 32'h0, 4'b0000, rd, er, waits);
        chk("t4 align err", 64'(er), 64'd1);
        chk("t4 align data", 64'(rd), 64'h0);

        // 5: two waits, PCLKEN one cycle in three
        div = 3;
        xfer(1, 16'h0008, 1'b1, 32'hCAFEF00D, 4'b1111, rd, er, waits);
        chk("t5 waits", 64'(waits), 64'd2);
        @(negedge clk);
        chk("t5 REG_OUT[2]", 64'(slot(reg_out1, 2)), 64'hCAFEF00D);
        div = 1;
        repeat (3) sync();

        // 6: reset during a write wait state
        xfer(0, 16'h000C, 1'b1, 32'h55AA55AA, 4'b1111, rd, er, waits);
        chk("t6 pre REG_OUT[3]", 64'(slot(reg_out0, 3)), 64'h55AA55AA);
        tgt = 0; paddr = 16'h000C; pwrite = 1'b1; pwdata = 32'h11111111; pstrb = 4'b1111;
        psel = 1'b1; penable = 1'b0;
        en_edge(er);
        #1 penable = 1'b1;
        @(negedge clk);
        chk("t6 wait PREADY", 64'(bus0.PREADY), 64'd0);
        #1 rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        #1;
        chk("t6 rst REG_OUT[3]", 64'(slot(reg_out0, 3)), 64'h0);
        chk("t6 rst REG_OUT[1]", 64'(slot(reg_out0, 1)), 64'h0);
        chk("t6 rst PRDATA", 64'(bus0.PRDATA), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        xfer(0, 16'h000C, 1'b1, 32'h0BADF00D, 4'b1111, rd, er, waits);
        chk("t6 post waits", 64'(waits), 64'd1);
        @(negedge clk);
        chk("t6 post REG_OUT[3]", 64'(slot(reg_out0, 3)), 64'h0BADF00D);
        chk("t6 post WR_PULSE", 64'(wr_pulse0), 64'h08);
        sync();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
